// File: rtl/debounce_edge_detector.sv
// debounce_edge_detector: per-channel synchroniser, debouncer and edge detector
// with sticky rise/fall flags combined into one interrupt.
module debounce_edge_detector #(
    parameter int WIDTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] level_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] p_edge,
    output logic [WIDTH-1:0] n_edge,
    output logic [WIDTH-1:0] any_edge,
    output logic [WIDTH-1:0] pend_rise,
    output logic [WIDTH-1:0] pend_fall,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_level, r_p, r_n, r_pr, r_pf;
    logic [WIDTH-1:0] w_s, w_diff, w_acc;

    always_comb begin
        w_s = r_sync[SYNC_STAGES-1];
        w_diff = w_s ^ r_level;
        w_acc = '0;
        for (int i = 0; i < WIDTH; i++)
            w_acc[i] = w_diff[i] && (r_cnt[i] == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
            r_level <= RESET_LEVEL;
            r_p <= '0;
            r_n <= '0;
            r_pr <= '0;
            r_pf <= '0;
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], level_in};
            r_level <= r_level ^ w_acc;
            r_p <= w_acc & w_s;
            r_n <= w_acc & ~w_s;
            // a new edge pulse wins over a simultaneous clear
            r_pr <= (r_pr & ~clr) | r_p;
            r_pf <= (r_pf & ~clr) | r_n;
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= (w_diff[i] && !w_acc[i]) ? r_cnt[i] + 1'b1 : '0;
        end
    end

    assign level_out = r_level;
    assign p_edge = r_p;
    assign n_edge = r_n;
    assign any_edge = r_p | r_n;
    assign pend_rise = r_pr;
    assign pend_fall = r_pf;
    assign irq = |((r_pr & rise_en) | (r_pf & fall_en));
endmodule
